// File: rtl/fxdiv_pkg.sv
// rtl/fxdiv_pkg.sv - shared types and sizing/saturation helpers for the fixed-point divider
package fxdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic int iter_of(input int width, input int frac);
        return width + frac;
    endfunction

    function automatic int cnt_w_of(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    function automatic logic [63:0] sat_max(input int width, input logic sgn);
        return sgn ? ((64'd1 << (width - 1)) - 64'd1) : ((64'd1 << width) - 64'd1);
    endfunction

    // Signed minimum as a magnitude; it equals the two's-complement pattern in width bits.
    function automatic logic [63:0] sat_min(input int width, input logic sgn);
        return sgn ? (64'd1 << (width - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/fxdiv_iter_cnt.sv
// rtl/fxdiv_iter_cnt.sv - iteration counter with clear, enable and carry-out on the last count
module fxdiv_iter_cnt
    import fxdiv_pkg::*;
#(
    parameter int ITER = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic co
);

    localparam int CW = cnt_w_of(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign co = en && (cnt == LAST);

endmodule

// File: rtl/fixed_point_divider_param.sv
// rtl/fixed_point_divider_param.sv - sequential restoring fixed-point divider, one quotient bit per clock
module fixed_point_divider_param
    import fxdiv_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int FRAC_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_mode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             ov,
    output logic             dvz,
    output logic             cnt_co
);

    localparam int ITER = iter_of(WIDTH, FRAC_BITS);

    localparam logic [63:0] U_MAX64 = sat_max(WIDTH, 1'b0);
    localparam logic [63:0] S_MAX64 = sat_max(WIDTH, 1'b1);
    localparam logic [63:0] S_MIN64 = sat_min(WIDTH, 1'b1);

    localparam logic [WIDTH-1:0] U_MAX = U_MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] S_MAX = S_MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] S_MIN = S_MIN64[WIDTH-1:0];
    localparam logic [ITER-1:0]  U_LIM = U_MAX64[ITER-1:0];
    localparam logic [ITER-1:0]  S_POS_LIM = S_MAX64[ITER-1:0];
    localparam logic [ITER-1:0]  S_NEG_LIM = S_MIN64[ITER-1:0];

    state_t state, state_nx;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sm_r, neg_q_r, neg_a_r;
    logic [WIDTH-1:0] b_mag_r, rem_r;
    logic [ITER-1:0]  num_r, quo_r;

    logic             accept, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic             unused_trial_bit;
    logic [WIDTH-1:0] q_fix, r_fix, q_dvz;
    logic             ov_fix;
    logic             cnt_clr, cnt_en, cnt_last;

    assign accept = (state == ST_IDLE) || (state == ST_DONE);

    assign a_neg  = sm_r && a_reg[WIDTH-1];
    assign b_neg  = sm_r && b_reg[WIDTH-1];
    assign a_mag  = a_neg ? -a_reg : a_reg;
    assign b_mag  = b_neg ? -b_reg : b_reg;
    assign b_zero = (b_reg == '0);

    // Partial remainder stays below |B|, so the shifted value needs one extra bit and the trial one more for borrow.
    assign rem_sh   = {rem_r, num_r[ITER-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, b_mag_r};
    assign trial_ok = ~trial[WIDTH+1];
    assign unused_trial_bit = trial[WIDTH];

    always_comb begin
        q_dvz = U_MAX;
        if (sm_r) begin
            if (a_reg == '0) begin
                q_dvz = '0;
            end else if (a_reg[WIDTH-1]) begin
                q_dvz = S_MIN;
            end else begin
                q_dvz = S_MAX;
            end
        end
    end

    always_comb begin
        ov_fix = 1'b0;
        q_fix  = quo_r[WIDTH-1:0];
        r_fix  = neg_a_r ? -rem_r : rem_r;
        if (!sm_r) begin
            if (quo_r > U_LIM) begin
                ov_fix = 1'b1;
                q_fix  = U_MAX;
            end
        end else if (!neg_q_r) begin
            if (quo_r > S_POS_LIM) begin
                ov_fix = 1'b1;
                q_fix  = S_MAX;
            end
        end else begin
            if (quo_r > S_NEG_LIM) begin
                ov_fix = 1'b1;
                q_fix  = S_MIN;
            end else begin
                q_fix = -quo_r[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_INIT;
            end
            ST_INIT: begin
                busy     = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = b_zero ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                busy   = 1'b1;
                cnt_en = 1'b1;
                if (cnt_last) state_nx = ST_FIX;
            end
            ST_FIX: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = start ? ST_INIT : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign cnt_co = cnt_last;

    fxdiv_iter_cnt #(
        .ITER(ITER)
    ) u_iter_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .co (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sm_r    <= 1'b0;
            neg_q_r <= 1'b0;
            neg_a_r <= 1'b0;
            b_mag_r <= '0;
            rem_r   <= '0;
            num_r   <= '0;
            quo_r   <= '0;
            q_out   <= '0;
            rem_out <= '0;
            ov      <= 1'b0;
            dvz     <= 1'b0;
        end else begin
            if (accept) begin
                if (ld_a) a_reg <= a_in;
                if (ld_b) b_reg <= b_in;
                if (start) begin
                    sm_r <= signed_mode;
                    ov   <= 1'b0;
                    dvz  <= 1'b0;
                end
            end
            case (state)
                ST_INIT: begin
                    if (b_zero) begin
                        dvz     <= 1'b1;
                        ov      <= 1'b0;
                        q_out   <= q_dvz;
                        rem_out <= '0;
                    end else begin
                        num_r   <= ITER'(a_mag) << FRAC_BITS;
                        b_mag_r <= b_mag;
                        rem_r   <= '0;
                        quo_r   <= '0;
                        neg_q_r <= a_neg ^ b_neg;
                        neg_a_r <= a_neg;
                    end
                end
                ST_CALC: begin
                    num_r <= num_r << 1;
                    rem_r <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo_r <= {quo_r[ITER-2:0], trial_ok};
                end
                ST_FIX: begin
                    q_out   <= q_fix;
                    rem_out <= r_fix;
                    ov      <= ov_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider_param.sv
// tb/tb_fixed_point_divider_param.sv - randomized self-checking bench for fixed_point_divider_param
module tb_fixed_point_divider_param;

    localparam int W    = 10;
    localparam int F    = 4;
    localparam int ITER = W + F;

    logic         clk = 1'b0;
    logic         rst, ld_a, ld_b, start, signed_mode;
    logic [W-1:0] a_in, b_in, q_out, rem_out;
    logic         busy, done, ov, dvz, cnt_co;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fixed_point_divider_param #(
        .WIDTH(W),
        .FRAC_BITS(F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ld_a(ld_a),
        .ld_b(ld_b),
        .a_in(a_in),
        .b_in(b_in),
        .signed_mode(signed_mode),
        .start(start),
        .busy(busy),
        .done(done),
        .q_out(q_out),
        .rem_out(rem_out),
        .ov(ov),
        .dvz(dvz),
        .cnt_co(cnt_co)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic on the real-valued operands scaled by 2^F, truncated toward zero.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic o, output logic z);
        longint av, bv, num, qt, rt, qq;
        longint umax, smax, smin;
        umax = (longint'(1) << W) - 1;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        av = longint'(a);
        bv = longint'(b);
        if (s && a[W-1]) av = av - (longint'(1) << W);
        if (s && b[W-1]) bv = bv - (longint'(1) << W);
        o = 1'b0;
        if (bv == 0) begin
            z  = 1'b1;
            rt = 0;
            if (!s)          qq = umax;
            else if (av == 0) qq = 0;
            else if (av < 0)  qq = smin;
            else              qq = smax;
        end else begin
            z   = 1'b0;
            num = av * (longint'(1) << F);
            qt  = num / bv;
            rt  = num - qt * bv;
            qq  = qt;
            if (!s && qt > umax) begin o = 1'b1; qq = umax; end
            if (s && qt > smax)  begin o = 1'b1; qq = smax; end
            if (s && qt < smin)  begin o = 1'b1; qq = smin; end
        end
        q = qq[W-1:0];
        r = rt[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        a_in = a;
        b_in = b;
        signed_mode = s;
        ld_a = 1'b1;
        ld_b = 1'b1;
        start = 1'b1;
        step();
        ld_a = 1'b0;
        ld_b = 1'b0;
        start = 1'b0;
    endtask

    // Entered one step after the start edge; returns in the done cycle.
    task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              input string tag, input int poke_at);
        logic [W-1:0] eq, er;
        logic         eo, ez, got_done;
        int           n, co_at, co_cnt;
        model(a, b, s, eq, er, eo, ez);
        n = 0;
        co_at = -1;
        co_cnt = 0;
        got_done = 1'b0;
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (n < 40) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cnt_co) begin
                co_cnt++;
                co_at = n;
            end
            if (n == poke_at) begin
                a_in = ~a;
                b_in = b + 10'd1;
                ld_a = 1'b1;
                ld_b = 1'b1;
                start = 1'b1;
            end
            step();
            n++;
            ld_a = 1'b0;
            ld_b = 1'b0;
            start = 1'b0;
        end
        check_eq({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check_eq({tag, "_latency"}, 32'(n), ez ? 32'd1 : 32'(ITER + 2));
        if (ez) begin
            check_eq({tag, "_co_count"}, 32'(co_cnt), 32'd0);
        end else begin
            check_eq({tag, "_co_count"}, 32'(co_cnt), 32'd1);
            check_eq({tag, "_co_pos"}, 32'(co_at), 32'(n - 2));
        end
        check_eq({tag, "_q"}, 32'(q_out), 32'(eq));
        check_eq({tag, "_rem"}, 32'(rem_out), 32'(er));
        check_eq({tag, "_ov"}, 32'(ov), 32'(eo));
        check_eq({tag, "_dvz"}, 32'(dvz), 32'(ez));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
    } vec_t;

    vec_t dir_tbl[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb, hold_q;
        logic         rs, seen;
        int           sel;

        rst = 1'b1;
        ld_a = 1'b0;
        ld_b = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a_in = '0;
        b_in = '0;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_q", 32'(q_out), 32'd0);
        check_eq("rst_rem", 32'(rem_out), 32'd0);
        check_eq("rst_ov", 32'(ov), 32'd0);
        check_eq("rst_dvz", 32'(dvz), 32'd0);
        check_eq("rst_cnt_co", 32'(cnt_co), 32'd0);
        rst = 1'b0;
        step();

        dir_tbl.push_back('{10'h06E, 10'h003, 1'b0, 10'h24A});
        dir_tbl.push_back('{10'h070, 10'h020, 1'b0, 10'h038});
        dir_tbl.push_back('{10'h3D0, 10'h010, 1'b1, 10'h3D0});
        dir_tbl.push_back('{10'h392, 10'h003, 1'b1, 10'h200});
        dir_tbl.push_back('{10'h005, 10'h000, 1'b0, 10'h3FF});
        dir_tbl.push_back('{10'h005, 10'h000, 1'b1, 10'h1FF});
        dir_tbl.push_back('{10'h3F0, 10'h000, 1'b1, 10'h200});
        dir_tbl.push_back('{10'h000, 10'h000, 1'b1, 10'h000});
        dir_tbl.push_back('{10'h3FF, 10'h001, 1'b0, 10'h3FF});
        dir_tbl.push_back('{10'h200, 10'h3F0, 1'b1, 10'h1FF});

        foreach (dir_tbl[i]) begin
            launch(dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].s);
            wait_check(dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].s, $sformatf("dir%0d", i), -1);
            check_eq($sformatf("dir%0d_tbl_q", i), 32'(q_out), 32'(dir_tbl[i].q));
            hold_q = q_out;
            step();
            check_eq($sformatf("dir%0d_done_pulse", i), 32'(done), 32'd0);
            step();
            check_eq($sformatf("dir%0d_hold_q", i), 32'(q_out), 32'(hold_q));
        end

        launch(10'h123, 10'h017, 1'b0);
        wait_check(10'h123, 10'h017, 1'b0, "busy_poke", 4);
        step();

        launch(10'h06E, 10'h003, 1'b0);
        wait_check(10'h06E, 10'h003, 1'b0, "b2b_first", -1);
        launch(10'h392, 10'h003, 1'b1);
        wait_check(10'h392, 10'h003, 1'b1, "b2b_second", -1);
        launch(10'h070, 10'h020, 1'b0);
        wait_check(10'h070, 10'h020, 1'b0, "b2b_third", -1);
        step();

        launch(10'h06E, 10'h003, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_q", 32'(q_out), 32'd0);
        check_eq("midrst_rem", 32'(rem_out), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            if (done) seen = 1'b1;
            step();
        end
        check_eq("midrst_no_done", 32'(seen), 32'd0);
        launch(10'h06E, 10'h003, 1'b0);
        wait_check(10'h06E, 10'h003, 1'b0, "midrst_clean", -1);
        step();

        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom());
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      rb = '0;
            else if (sel == 1) rb = W'($urandom_range(1, 7));
            else               rb = W'($urandom());
            rs = 1'($urandom_range(0, 1));
            launch(ra, rb, rs);
            wait_check(ra, rb, rs, $sformatf("rnd%0d", i), -1);
            if ($urandom_range(0, 1) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
